// File: rtl/game_pkg.sv
// Game-level types and helpers shared by score_ctl and the score display block.
package game_pkg;

  import vga_pkg::*;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_PLAY,
    ST_HOLD,
    ST_RRST,
    ST_OVER
  } game_state_t;

  localparam int WIN_SCORE_DEFAULT = 9;
  localparam int SCORE_W           = 4;
  localparam int CNT_W             = 27;

  // Positions at or beyond this value are the ball having wrapped off the left edge.
  localparam int GOAL_WRAP = 1536;

  function automatic logic isLeftGoal(input logic [XPOS_W-1:0] xpos);
    return (xpos == '0) || (xpos >= XPOS_W'(GOAL_WRAP));
  endfunction

  function automatic logic isRightGoal(input logic [XPOS_W-1:0] xpos);
    return (xpos >= XPOS_W'(HOR_PIXELS)) && (xpos < XPOS_W'(GOAL_WRAP));
  endfunction

  function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] s,
                                                input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? lim : s + 1'b1;
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// Display timing constants shared by the video pipeline and the game logic.
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int XPOS_W     = 11;

endpackage

// File: rtl/delay_cnt.sv
// Loadable down-counter that parks at zero; o_zero marks the end of a delay.
module delay_cnt
  import game_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (!o_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/score_ctl.sv
// Round/score sequencer: detects goals, keeps both scores, freezes the ball,
// pulses round_rst to ball_ctl and declares the winner.
module score_ctl
  import game_pkg::*;
#(
  parameter int HOLD_CYCLES = 40_000_000,
  parameter int RST_CYCLES  = 4,
  parameter int WIN_SCORE   = WIN_SCORE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] ball_xpos,
  input  logic        game_rst,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        round_rst,
  output logic        game_over,
  output logic        winner
);

  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RRST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  game_state_t        r_state;
  game_state_t        w_next_state;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;
  logic [SCORE_W-1:0] w_score_l_next;
  logic [SCORE_W-1:0] w_score_r_next;
  logic               r_round_rst;
  logic               r_game_over;
  logic               r_winner;
  logic               w_game_over_next;
  logic               w_winner_next;
  logic               w_left_goal;
  logic               w_right_goal;
  logic               w_win_reached;
  logic               w_cnt_load;
  logic [CNT_W-1:0]   w_cnt_load_val;
  logic               w_cnt_zero;

  assign w_left_goal   = isLeftGoal(ball_xpos);
  assign w_right_goal  = isRightGoal(ball_xpos);
  assign w_win_reached = (r_score_l == WIN_VAL) || (r_score_r == WIN_VAL);

  delay_cnt #(
    .RST_VAL(RRST_LOAD)
  ) u_delay_cnt (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_load    (w_cnt_load),
    .i_load_val(w_cnt_load_val),
    .o_zero    (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RRST;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A new-game request overrides everything, including a goal seen in the same cycle.
  always_comb begin
    w_next_state     = r_state;
    w_cnt_load       = 1'b0;
    w_cnt_load_val   = RRST_LOAD;
    w_score_l_next   = r_score_l;
    w_score_r_next   = r_score_r;
    w_game_over_next = r_game_over;
    w_winner_next    = r_winner;
    if (game_rst) begin
      w_next_state     = ST_RRST;
      w_cnt_load       = 1'b1;
      w_cnt_load_val   = RRST_LOAD;
      w_score_l_next   = '0;
      w_score_r_next   = '0;
      w_game_over_next = 1'b0;
    end else begin
      unique case (r_state)
        ST_ARM: begin
          if (!w_left_goal && !w_right_goal) begin
            w_next_state = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (w_left_goal) begin
            w_score_r_next = satInc(r_score_r, WIN_VAL);
            w_next_state   = ST_HOLD;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = HOLD_LOAD;
          end else if (w_right_goal) begin
            w_score_l_next = satInc(r_score_l, WIN_VAL);
            w_next_state   = ST_HOLD;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (w_cnt_zero) begin
            if (w_win_reached) begin
              w_next_state     = ST_OVER;
              w_game_over_next = 1'b1;
              w_winner_next    = (r_score_r == WIN_VAL);
            end else begin
              w_next_state   = ST_RRST;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = RRST_LOAD;
            end
          end
        end
        ST_RRST: begin
          if (w_cnt_zero) begin
            w_next_state = ST_ARM;
          end
        end
        ST_OVER: begin
          w_next_state = ST_OVER;
        end
        default: begin
          w_next_state   = ST_RRST;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = RRST_LOAD;
        end
      endcase
    end
  end

  // round_rst is the registered image of the RRST state, so ball_ctl sees a clean pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
      r_round_rst <= 1'b0;
    end else begin
      r_score_l   <= w_score_l_next;
      r_score_r   <= w_score_r_next;
      r_game_over <= w_game_over_next;
      r_winner    <= w_winner_next;
      r_round_rst <= (r_state == ST_RRST);
    end
  end

  assign score_l   = r_score_l;
  assign score_r   = r_score_r;
  assign round_rst = r_round_rst;
  assign game_over = r_game_over;
  assign winner    = r_winner;

endmodule

// File: tb/tb_score_ctl.sv
// Randomised scoreboard bench for score_ctl: a round-level timeline model predicts
// every output change, and a negedge monitor matches each observed change in order.
module tb_score_ctl;

  import game_pkg::*;

  localparam int HOLD = 10;
  localparam int RSTC = 4;
  localparam int WIN  = 3;

  localparam int K_SL = 0;
  localparam int K_SR = 1;
  localparam int K_RR = 2;
  localparam int K_GO = 3;

  typedef struct {
    int at;
    int kind;
    int value;
  } evt_t;

  logic        clk;
  logic        rst;
  logic [10:0] ball_xpos;
  logic        game_rst;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        round_rst;
  logic        game_over;
  logic        winner;

  int   cyc = 0;
  int   assertCount = 0;
  int   failCount = 0;
  evt_t expQ[$];

  int drvEdge = 0;
  int lastGoalEdge = -100;
  int stateCheckAt = -1;
  int rrstEdge = 0;
  int modelL = 0;
  int modelR = 0;
  int modelOver = 0;
  int overAt = 0;

  logic [3:0] prevL = '0;
  logic [3:0] prevR = '0;
  logic       prevRR = 1'b0;
  logic       prevGO = 1'b0;
  logic       monOn = 1'b0;

  score_ctl #(
    .HOLD_CYCLES(HOLD),
    .RST_CYCLES (RSTC),
    .WIN_SCORE  (WIN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ball_xpos(ball_xpos),
    .game_rst (game_rst),
    .score_l  (score_l),
    .score_r  (score_r),
    .round_rst(round_rst),
    .game_over(game_over),
    .winner   (winner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kindName(input int k);
    case (k)
      K_SL:    return "score_l";
      K_SR:    return "score_r";
      K_RR:    return "round_rst";
      default: return "game_over";
    endcase
  endfunction

  function automatic bit refLeft(input logic [10:0] x);
    return (x == 11'd0) || (x >= 11'd1536);
  endfunction

  function automatic bit refRight(input logic [10:0] x);
    return (x >= 11'd1024) && (x < 11'd1536);
  endfunction

  function automatic logic [10:0] neutralPos();
    return 11'($urandom_range(1, 1023));
  endfunction

  function automatic logic [10:0] goalPos();
    case ($urandom_range(0, 3))
      0:       return 11'd0;
      1:       return 11'($urandom_range(1536, 2047));
      default: return 11'($urandom_range(1024, 1535));
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input int at, input int kind, input int value);
    evt_t t;
    t.at    = at;
    t.kind  = kind;
    t.value = value;
    expQ.push_back(t);
  endtask

  task automatic observe(input int kind, input int value);
    evt_t t;
    assertCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL unexpected %s change: got %0d at cycle %0d, expected no change",
               kindName(kind), value, cyc);
    end else begin
      t = expQ.pop_front();
      if (t.at != cyc || t.kind != kind || t.value != value) begin
        failCount++;
        $display("[TB] FAIL event: got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d",
                 kindName(kind), value, cyc, kindName(t.kind), t.value, t.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (score_l != prevL) observe(K_SL, int'(score_l));
      if (score_r != prevR) observe(K_SR, int'(score_r));
      if (round_rst != prevRR) observe(K_RR, int'(round_rst));
      if (game_over != prevGO) observe(K_GO, game_over ? 2 + int'(winner) : 0);
    end
    prevL  <= score_l;
    prevR  <= score_r;
    prevRR <= round_rst;
    prevGO <= game_over;
  end

  task automatic applyStimulus(input logic [10:0] x, input logic g, input logic r);
    @(negedge clk);
    if (cyc == stateCheckAt) checkOutput("state PLAY", int'(dut.r_state == ST_PLAY), 1);
    ball_xpos = x;
    game_rst  = g;
    rst       = r;
    drvEdge   = cyc + 1;
    if (refLeft(x) || refRight(x)) lastGoalEdge = drvEdge;
  endtask

  // The round restart pulse follows the RRST entry edge by one cycle and lasts RSTC cycles.
  task automatic startRrst(input int e);
    rrstEdge = e;
    pushExp(e + 1, K_RR, 1);
    pushExp(e + 1 + RSTC, K_RR, 0);
  endtask

  task automatic clearGame(input int e);
    if (modelL != 0) pushExp(e, K_SL, 0);
    if (modelR != 0) pushExp(e, K_SR, 0);
    if (modelOver != 0) pushExp(e, K_GO, 0);
    modelL    = 0;
    modelR    = 0;
    modelOver = 0;
  endtask

  // mode 0: plain goal; 1: game_rst with the goal; 2: game_rst h cycles into the freeze;
  // 3: rst for two cycles starting h cycles into the freeze.
  task automatic playRound(input logic [10:0] gx, input int lead, input int dwell,
                           input int mode, input int h);
    int a;
    int g;
    int endE;
    a = (lastGoalEdge + 1 > rrstEdge + RSTC + 1) ? lastGoalEdge + 1 : rrstEdge + RSTC + 1;
    g = a + 1 + lead;
    while (drvEdge + 1 < g) applyStimulus(neutralPos(), 1'b0, 1'b0);
    if (mode == 1) begin
      clearGame(g);
      startRrst(g);
    end else begin
      if (refLeft(gx)) begin
        if (modelR < WIN) modelR++;
        pushExp(g, K_SR, modelR);
      end else begin
        if (modelL < WIN) modelL++;
        pushExp(g, K_SL, modelL);
      end
      if (mode == 2) begin
        clearGame(g + h);
        startRrst(g + h);
      end else if (mode == 3) begin
        clearGame(g + h);
        startRrst(g + h + 1);
      end else if (modelL == WIN || modelR == WIN) begin
        modelOver = 1;
        overAt    = g + HOLD;
        pushExp(overAt, K_GO, 2 + ((modelR == WIN) ? 1 : 0));
      end else begin
        startRrst(g + HOLD);
      end
    end
    endE = g + dwell - 1;
    if (mode == 2 && g + h > endE) endE = g + h;
    if (mode == 3 && g + h + 1 > endE) endE = g + h + 1;
    for (int e = g; e <= endE; e++) begin
      applyStimulus((e < g + dwell) ? gx : neutralPos(),
                    (mode == 1 && e == g) || (mode == 2 && e == g + h),
                    (mode == 3 && (e == g + h || e == g + h + 1)));
    end
  endtask

  task automatic finishGame(input int junk);
    int x;
    while (drvEdge < overAt + junk) applyStimulus(11'($urandom_range(0, 2047)), 1'b0, 1'b0);
    x = drvEdge + 1;
    clearGame(x);
    startRrst(x);
    applyStimulus(11'($urandom_range(0, 2047)), 1'b1, 1'b0);
  endtask

  initial begin
    int mode;
    rst       = 1'b1;
    game_rst  = 1'b0;
    ball_xpos = 11'd512;
    startRrst(2);
    stateCheckAt = 2 + RSTC + 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset score_l", int'(score_l), 0);
    checkOutput("reset score_r", int'(score_r), 0);
    checkOutput("reset game_over", int'(game_over), 0);
    checkOutput("reset winner", int'(winner), 0);
    monOn   = 1'b1;
    rst     = 1'b0;
    drvEdge = 3;

    playRound(11'd0, 2, 50, 0, 0);
    repeat (3) playRound(11'd1024, 1, 5, 0, 0);
    finishGame(30);
    playRound(11'd2047, 0, 3, 0, 0);
    playRound(11'd0, 1, 4, 1, 0);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 9))
        0:       mode = 1;
        1:       mode = 2;
        2:       mode = 3;
        default: mode = 0;
      endcase
      playRound(goalPos(), $urandom_range(0, 6), $urandom_range(1, 30), mode,
                $urandom_range(1, HOLD - 1));
      if (modelOver != 0) finishGame($urandom_range(0, 20));
    end

    repeat (40) applyStimulus(neutralPos(), 1'b0, 1'b0);
    checkOutput("pending events drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/score_ctl.md
SCORE_CTL -- requirements
Module: score_ctl

Interface
REQ-001 Parameter HOLD_CYCLES, default 40_000_000: cycles the scored ball stays frozen before round restart.
REQ-002 Parameter RST_CYCLES, default 4: length in cycles of the round_rst pulse to ball_ctl.
REQ-003 Parameter WIN_SCORE, default 9: score that ends the game.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ball_xpos  input  11  ball x position from ball_ctl.
REQ-007 game_rst  input  1  single-cycle, synchronised new-game request from the start button.
REQ-008 score_l  output  4  left player score.
REQ-009 score_r  output  4  right player score.
REQ-010 round_rst  output  1  restart request, wired OR'ed into ball_ctl rst.
REQ-011 game_over  output  1  high while a winner is declared.
REQ-012 winner  output  1  0 = left, 1 = right; valid while game_over.

Function
REQ-013 Goal zones decoded combinationally: LEFT_GOAL = ball_xpos==0 or ball_xpos>=1536 (wrap guard); RIGHT_GOAL = HOR_PIXELS<=ball_xpos<1536.
REQ-014 FSM states: ARM, PLAY, HOLD, RRST, OVER.
REQ-015 ARM: round_rst low; go to PLAY on the first cycle with neither goal zone active.
REQ-016 PLAY, LEFT_GOAL: score_r+1, enter HOLD; RIGHT_GOAL: score_l+1, enter HOLD; at most one increment per goal; score registers update 1 cycle after the decode.
REQ-017 HOLD: down-counter loaded with HOLD_CYCLES-1 on entry; at 0, go to OVER if either score == WIN_SCORE, else to RRST.
REQ-018 RRST: round_rst high for exactly RST_CYCLES consecutive cycles, then ARM.
REQ-019 OVER: game_over=1, winner set from the score equal to WIN_SCORE, round_rst low; ball left frozen.
REQ-020 game_rst in any state: clear both scores, clear game_over, enter RRST next cycle; takes priority over a same-cycle goal, which is not counted.
REQ-021 Scores saturate at WIN_SCORE; no 4-bit wrap.
REQ-022 round_rst, game_over, winner driven straight from registers, no combinational path from inputs.
REQ-023 Counter is 27 bits; HOLD_CYCLES and RST_CYCLES >= 1.

Reset
REQ-024 On rst: state RRST, score_l=0, score_r=0, game_over=0, winner=0, counter loaded with RST_CYCLES-1, so round_rst is high for RST_CYCLES cycles after rst releases.
REQ-025 rst mid-HOLD or mid-RRST aborts the current count; no score change is kept from the aborted cycle.

Structure
REQ-026 HOR_PIXELS is taken from vga_pkg; the state enum and WIN_SCORE default live in a new game_pkg, shared with the score display block.
REQ-027 One sub-module is natural: delay_cnt, a loadable 27-bit down-counter with load/zero flag, used by HOLD and RRST; everything else is in score_ctl.

Verification
REQ-028 Bench runs with HOLD_CYCLES=10, RST_CYCLES=4, WIN_SCORE=3.
REQ-029 rst for 2 cycles, then ball_xpos=512 -> round_rst high for 4 cycles, state reaches PLAY, scores 0/0.
REQ-030 In PLAY, ball_xpos=0 held for 50 cycles -> score_r=1 once, round_rst high exactly 4 cycles starting 11 cycles after the increment; no second increment while xpos stays 0 through ARM.
REQ-031 ball_xpos=1024 (HOR_PIXELS) three rounds -> score_l=3, game_over=1, winner=0, round_rst stays low until game_rst.
REQ-032 ball_xpos=2047 in PLAY -> counted as a left goal (score_r+1), not as a right goal.
REQ-033 game_rst in the same cycle as ball_xpos=0 in PLAY -> scores 0/0, game_over=0, round_rst 4 cycles, no increment.
